// File: rtl/block_copy_engine_pkg.sv
// Shared types for the byte copy engine: FSM state encoding and the
// descriptor layout that upstream store_* blocks use to issue copies.
package block_copy_engine_pkg;

   localparam int BCE_DDR3_AW = 28;
   localparam int BCE_DST_AW  = 25;
   localparam int BCE_LEN_W   = 25;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR      = 3'd3,
      ST_WR_WAIT = 3'd4,
      ST_FINISH  = 3'd5
   } copy_state_t;

   typedef struct packed {
      logic [BCE_DDR3_AW-1:0] src;
      logic [BCE_DST_AW-1:0]  dst;
      logic [BCE_LEN_W-1:0]   length;
      logic                   target;
      logic                   fill_en;
      logic [7:0]             fill_value;
   } copy_desc_t;

endpackage

// File: rtl/block_copy_engine.sv
// Byte-wide copy/fill engine: moves bytes from the DDR3 staging area into
// BRAM or SDRAM, or writes a constant fill byte without touching DDR3.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; descriptor latched on start
// RD_REQ   | one-cycle DDR3 read strobe at the current source address
// RD_WAIT  | waiting for ddr3_ready, then capture the read byte
// WR       | BRAM write (single cycle) or SDRAM write once sdram_ready
// WR_WAIT  | waiting for the SDRAM write to complete
// FINISH   | drop requests, raise done/aborted on the following cycle
module block_copy_engine
   import block_copy_engine_pkg::*;
#(
   parameter int DDR3_AW = BCE_DDR3_AW,
   parameter int DST_AW  = BCE_DST_AW,
   parameter int LEN_W   = BCE_LEN_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [DDR3_AW-1:0] src_addr,
   input  logic [DST_AW-1:0]  dst_addr,
   input  logic [LEN_W-1:0]   length,
   input  logic               target,
   input  logic               fill_en,
   input  logic [7:0]         fill_value,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [LEN_W-1:0]   byte_count,
   output logic [DDR3_AW-1:0] ddr3_addr,
   output logic               ddr3_rd,
   input  logic [7:0]         ddr3_dout,
   input  logic               ddr3_ready,
   output logic               ddr3_request,
   output logic [DST_AW-1:0]  bram_addr,
   output logic [7:0]         bram_din,
   output logic               bram_we,
   output logic               bram_request,
   output logic [DST_AW-1:0]  sdram_addr,
   output logic [7:0]         sdram_din,
   output logic               sdram_we,
   output logic               sdram_request,
   input  logic               sdram_ready
);

   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] RD_REQ  = ST_RD_REQ;
   localparam logic [2:0] RD_WAIT = ST_RD_WAIT;
   localparam logic [2:0] WR      = ST_WR;
   localparam logic [2:0] WR_WAIT = ST_WR_WAIT;
   localparam logic [2:0] FINISH  = ST_FINISH;

   logic [2:0]         state;
   logic [2:0]         state_nx;
   logic [2:0]         byte_nx;
   logic [DDR3_AW-1:0] src;
   logic [DST_AW-1:0]  dst;
   logic [LEN_W-1:0]   remaining;
   logic [7:0]         data;
   logic               tgt;
   logic               fill;
   logic               abort_flag;
   logic               dst_owned;
   logic               wr_done;
   logic               last_byte;

   // A byte is finished when the BRAM write fires or the SDRAM write completes.
   assign wr_done   = ((state == WR) && !tgt) || ((state == WR_WAIT) && sdram_ready);
   assign last_byte = (remaining == LEN_W'(1));

   // Where to go after a completed write; the final byte beats a pending abort.
   always_comb begin
      byte_nx = fill ? WR : RD_REQ;
      if (last_byte || abort) begin
         byte_nx = FINISH;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  state_nx = FINISH;
               end else if (fill_en) begin
                  state_nx = WR;
               end else begin
                  state_nx = RD_REQ;
               end
            end
         end
         RD_REQ:  state_nx = RD_WAIT;
         RD_WAIT: if (ddr3_ready) state_nx = WR;
         WR: begin
            if (!tgt) begin
               state_nx = byte_nx;
            end else if (sdram_ready) begin
               state_nx = WR_WAIT;
            end
         end
         WR_WAIT: if (sdram_ready) state_nx = byte_nx;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, descriptor registers, address/length counters and status pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         src        <= '0;
         dst        <= '0;
         remaining  <= '0;
         data       <= '0;
         tgt        <= 1'b0;
         fill       <= 1'b0;
         abort_flag <= 1'b0;
         dst_owned  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         byte_count <= '0;
      end else begin
         state   <= state_nx;
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  src        <= src_addr;
                  dst        <= dst_addr;
                  remaining  <= length;
                  tgt        <= target;
                  fill       <= fill_en;
                  data       <= fill_value;
                  abort_flag <= 1'b0;
                  busy       <= 1'b1;
                  byte_count <= '0;
               end
            end
            RD_WAIT: begin
               if (ddr3_ready) begin
                  data <= ddr3_dout;
               end
            end
            FINISH: begin
               done    <= !abort_flag;
               aborted <= abort_flag;
               busy    <= 1'b0;
            end
            default: ;
         endcase
         if (wr_done) begin
            src        <= src + DDR3_AW'(1);
            dst        <= dst + DST_AW'(1);
            remaining  <= remaining - LEN_W'(1);
            byte_count <= byte_count + LEN_W'(1);
            if (!last_byte && abort) begin
               abort_flag <= 1'b1;
            end
         end
         // Destination ownership is held from the first write until FINISH,
         // including the read phases between bytes.
         if (state_nx == WR) begin
            dst_owned <= 1'b1;
         end else if ((state_nx == FINISH) || (state_nx == IDLE)) begin
            dst_owned <= 1'b0;
         end
      end
   end

   assign ddr3_addr     = src;
   assign ddr3_rd       = (state == RD_REQ);
   assign ddr3_request  = (state == RD_REQ) || (state == RD_WAIT);

   assign bram_addr     = dst;
   assign bram_din      = data;
   assign bram_we       = (state == WR) && !tgt;
   assign bram_request  = dst_owned && !tgt;

   assign sdram_addr    = dst;
   assign sdram_din     = data;
   assign sdram_we      = (state == WR) && tgt && sdram_ready;
   assign sdram_request = dst_owned && tgt;

endmodule

// File: doc/block_copy_engine.md
Name: block_copy_engine

Overview:
- Byte-wide copy engine downstream of the download configuration stages.
- Takes one descriptor (DDR3 source, destination, length, target) and streams bytes from the DDR3 staging area into BRAM or SDRAM, one byte at a time.
- Also supports fill mode, which writes a constant byte with no DDR3 reads; used to initialise RAM blocks and SRAM images.
- The download top muxes its ddr3_*, bram_* and sdram_* request groups exactly as it does for the other requesters.

Parameters:
- DDR3_AW, 28, DDR3 byte address width
- DST_AW, 25, destination byte address width (BRAM and SDRAM)
- LEN_W, 25, byte length width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches the descriptor when idle
- abort  in  1  level; stops the copy at the next byte boundary
- src_addr  in  DDR3_AW  DDR3 start byte address
- dst_addr  in  DST_AW  destination start byte address
- length  in  LEN_W  byte count; 0 is legal
- target  in  1  0 = BRAM, 1 = SDRAM
- fill_en  in  1  1 = write fill_value, do not read DDR3
- fill_value  in  8  fill byte
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort completion
- byte_count  out  LEN_W  bytes written so far
- ddr3_addr  out  DDR3_AW  read address
- ddr3_rd  out  1  one-cycle read strobe
- ddr3_dout  in  8  read data
- ddr3_ready  in  1  high = idle / data valid
- ddr3_request  out  1  bus ownership request to the top mux
- bram_addr  out  DST_AW  write address
- bram_din  out  8  write data
- bram_we  out  1  write strobe
- bram_request  out  1  ownership request
- sdram_addr  out  DST_AW  write address
- sdram_din  out  8  write data
- sdram_we  out  1  write strobe
- sdram_request  out  1  ownership request
- sdram_ready  in  1  high = previous write complete

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs are 0: strobes, requests, busy, done, aborted, byte_count and addresses.
- States: IDLE, RD_REQ, RD_WAIT, WR, WR_WAIT, FINISH.
- IDLE:
  - On start, latch src, dst, remaining=length, target, fill_en and fill_value. Clear byte_count.
  - Descriptor inputs are ignored at all other times; start while busy is ignored.
  - If length==0, go to FINISH. Otherwise go to WR when fill_en=1, else RD_REQ.
- RD_REQ:
  - ddr3_request=1. ddr3_rd pulses for exactly 1 cycle with ddr3_addr=src.
  - Next state is RD_WAIT.
- RD_WAIT:
  - The first cycle with ddr3_ready=1, no earlier than 1 cycle after the strobe, captures ddr3_dout into the data register.
  - Then go to WR.
- WR (BRAM target):
  - bram_we=1 for 1 cycle with bram_addr=dst and bram_din=data.
  - The write is complete in the same cycle.
- WR (SDRAM target):
  - Wait for sdram_ready=1, then pulse sdram_we for 1 cycle and go to WR_WAIT.
- WR_WAIT:
  - Wait until sdram_ready=1, no earlier than 1 cycle after the strobe.
- After each completed write:
  - src+=1 (wraps at 2^DDR3_AW), dst+=1 (wraps at 2^DST_AW), remaining-=1, byte_count+=1.
  - remaining==0 goes to FINISH. abort=1 goes to FINISH with the abort flag set. Otherwise go to RD_REQ, or WR in fill mode.
- abort rules:
  - Sampled only at byte boundaries; an outstanding DDR3 read or SDRAM write always completes.
  - Aborting in IDLE has no effect.
  - If abort and the final byte coincide, completion wins: done pulses and aborted does not.
- Request signals:
  - ddr3_request is high from RD_REQ through RD_WAIT.
  - bram_request or sdram_request (selected by target) is high from the first WR until FINISH.
  - Requests drop in FINISH.
- FINISH:
  - Pulse done (or aborted) for 1 cycle, busy=0, then go to IDLE. start in that same cycle is ignored.
- Throughput limits:
  - BRAM fill: 1 byte per cycle; the WR state self-loops.
  - Copy: at least 3 cycles per byte.
- Reset mid-copy abandons the transfer immediately. No done and no aborted pulse is produced.

Decomposition:
- Shared MSX package: state enum copy_state_t and a copy_desc_t struct (src, dst, length, target, fill_en, fill_value), so store_* blocks can issue descriptors.
- No sub-module: single FSM plus datapath counters.

Test Plan:
- BRAM copy, src=0x100, dst=0x20, length=4, ddr3_ready delayed 2 cycles → 4 bram_we pulses at 0x20..0x23 with DDR3 bytes 0x100..0x103; done once; byte_count=4.
- SDRAM fill, fill_value=0xFF, length=3, sdram_ready low 3 cycles after each we → 3 sdram_we at dst..dst+2, no ddr3_rd, done.
- length=0 → no strobes; done pulses 2 cycles after start; busy high for 1 cycle.
- abort asserted during the 2nd RD_WAIT of a length=8 copy → byte 2 is still written; aborted pulses; byte_count=2; no done.
- dst=0x1FFFFFF, length=2 → writes at 0x1FFFFFF then 0x0000000.
- Async reset during WR_WAIT → all outputs 0 immediately; later start with a new descriptor runs cleanly.
